fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter merging requester streams into one FIFO write port
// Grants are held for one packet or MAX_BURST beats; words pass through with zero latency.
module fifo_wr_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            s_valid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_PORTS-1:0]            s_last,
  output logic [NUM_PORTS-1:0]            s_ready,
  output logic                            wr_en,
  output logic [DATA_WIDTH-1:0]           wr_data,
  input  logic                            wr_full,
  output logic [$clog2(NUM_PORTS)-1:0]    grant_id,
  output logic                            busy
);

  localparam int IDW = $clog2(NUM_PORTS);
  localparam int CW  = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q;
  logic [IDW-1:0]  last_q;
  logic [IDW-1:0]  sel_idx;
  logic            sel_found;
  logic [CW-1:0]   beat_cnt_q;
  logic            granted;
  logic            beat;
  logic [DATA_WIDTH-1:0] port_data [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign port_data[i] = s_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Outputs are gated by rst so nothing leaks out during the reset cycle itself.
  assign granted = (state_q == GRANT) && !rst;
  assign beat    = granted && !wr_full && s_valid[grant_id];
  assign wr_en   = beat;
  assign wr_data = beat ? port_data[grant_id] : '0;
  assign busy    = granted;

  always_comb begin
    s_ready = '0;
    if (granted && !wr_full) s_ready[grant_id] = 1'b1;
  end

  // Circular search starting just after the most recently released port.
  always_comb begin
    logic [IDW-1:0] idx;
    sel_found = 1'b0;
    sel_idx   = last_q;
    idx       = last_q;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (idx == IDW'(NUM_PORTS - 1)) ? '0 : idx + IDW'(1);
      if (!sel_found && s_valid[idx]) begin
        sel_found = 1'b1;
        sel_idx   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      grant_id   <= '0;
      last_q     <= IDW'(NUM_PORTS - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            grant_id   <= sel_idx;
            beat_cnt_q <= '0;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          if (beat) begin
            beat_cnt_q <= beat_cnt_q + CW'(1);
            if (s_last[grant_id] || beat_cnt_q == CW'(MAX_BURST - 1)) begin
              state_q <= IDLE;
              last_q  <= grant_id;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
